btn_conditioner: RTL

BTN_CONDITIONER -- requirements
Module: btn_conditioner

---
 rtl/btn_cond_pkg.sv | 26 ++
 rtl/debounce_bit.sv | 41 ++++
 rtl/btn_conditioner.sv | 85 ++++++++
 3 files changed

// File: rtl/btn_cond_pkg.sv
// btn_cond_pkg: shared reset-FSM state type, default timing constants and counter sizing
package btn_cond_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMING   = 2'd1,
    ASSERT   = 2'd2,
    WAIT_REL = 2'd3
  } rst_state_t;

  localparam int DEF_DB_CYCLES    = 1000000;
  localparam int DEF_HOLD_CYCLES  = 100000000;
  localparam int DEF_PULSE_CYCLES = 16;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // One width shared by every counter so any of them can hold its terminal value
  function automatic int cnt_width(input int a, input int b, input int c);
    return $clog2(max3(a, b, c) + 1);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: two-flop synchronizer, stable-count debounce and rising-edge pulse for one button
module debounce_bit
  import btn_cond_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES,
  parameter int CW        = $clog2(DB_CYCLES + 1)
) (
  input  logic clk,
  input  logic resetn,
  input  logic raw,
  output logic db,
  output logic rise
);

  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          db_q;

  // Synchronize, count disagreement cycles, adopt the new level once it has been stable long enough
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync <= '0;
      cnt  <= '0;
      db   <= 1'b0;
      db_q <= 1'b0;
      rise <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      db_q <= db;
      rise <= db & ~db_q;
      if (sync[1] == db) cnt <= '0;
      else if (cnt >= LAST) begin
        db  <= sync[1];
        cnt <= '0;
      end else cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: button debounce, switch synchronization and two-button hold-to-reset FSM
module btn_conditioner
  import btn_cond_pkg::*;
#(
  parameter int DB_CYCLES    = DEF_DB_CYCLES,
  parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES,
  parameter int PULSE_CYCLES = DEF_PULSE_CYCLES
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  btn_raw,
  input  logic [15:0] sw_raw,
  output logic [3:0]  btn_db,
  output logic [3:0]  btn_rise,
  output logic [15:0] sw_sync,
  output logic        sys_resetn,
  output logic [1:0]  rst_state
);

  localparam int CW = cnt_width(DB_CYCLES, HOLD_CYCLES, PULSE_CYCLES);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);

  rst_state_t    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          rstn_n;
  logic [15:0]   sw_meta;
  logic          both, any;

  for (genvar i = 0; i < 4; i++) begin : g_db
    debounce_bit #(.DB_CYCLES(DB_CYCLES), .CW(CW)) u_db (
      .clk    (clk),
      .resetn (resetn),
      .raw    (btn_raw[i]),
      .db     (btn_db[i]),
      .rise   (btn_rise[i])
    );
  end

  assign both      = btn_db[0] & btn_db[1];
  assign any       = btn_db[0] | btn_db[1];
  assign rst_state = state;

  // Switches need only metastability protection, no debounce
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw_raw;
      sw_sync <= sw_meta;
    end
  end

  // Next state, shared hold/pulse counter, and the registered reset request derived from next state
  always_comb begin
    state_n = state;
    cnt_n   = '0;
    case (state)
      IDLE:     state_n = both ? ARMING : IDLE;
      ARMING:   if (!both) state_n = IDLE;
                else if (cnt >= HOLD_LAST) state_n = ASSERT;
                else cnt_n = cnt + CW'(1);
      ASSERT:   if (cnt >= PULSE_LAST) state_n = WAIT_REL;
                else cnt_n = cnt + CW'(1);
      WAIT_REL: state_n = any ? WAIT_REL : IDLE;
      default:  state_n = IDLE;
    endcase
    rstn_n = (state_n == IDLE) || (state_n == ARMING);
  end

  // State, counter and sys_resetn all come straight from flops so the reset request cannot glitch
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      cnt        <= '0;
      sys_resetn <= 1'b1;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      sys_resetn <= rstn_n;
    end
  end

endmodule
